vending_fsm_multi: RTL and testbench

//  Parametrised successor to the single-product vending FSM. It accumulates credit over

---
 rtl/vending_fsm_multi.sv | 235 +++++++++++++++++++++++
 tb/tb_vending_fsm_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm_multi.sv
// -----------------------------------------------------------------------------
// vending_fsm_multi
//
// Multi-product vending controller. It accumulates credit from validated
// coins and vends one of NUM_PRODUCTS slots priced by a per-slot cost table.
// Any remaining credit after a vend is returned as change. Credit is refunded
// on cancel or after TIMEOUT_CYC idle cycles in CREDIT. Invalid coins, and
// coins that would push credit past MAX_CREDIT, are handed straight back.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   money_inserted         1-cycle coin strobe
//   inserted_money_valid   validator verdict, sampled with the coin strobe
//   inserted_money_value   coin value, sampled with the coin strobe
//   product_selected       1-cycle selection strobe
//   product_sel            selected slot index
//   product_cost           cost table; slot i at [i*WIDTH +: WIDTH]
//   product_available      per-slot stock flag
//   cancel                 1-cycle refund request
//   return_money           1-cycle pulse: rejected coin or refund
//   deliver_product        1-cycle dispense pulse
//   delivered_id           dispensed slot, valid with deliver_product
//   return_change          1-cycle change pulse
//   change_value           amount for return_money / return_change (held)
//   sel_error              1-cycle pulse: bad index, sold out or short credit
//   credit                 current accumulated credit
//   busy                   high while in CHECK / DELIVER / CHANGE / REFUND
//
// Every output is a flop. A pulse appears in the cycle after the state
// (or the sampled strobe) that produced it.
// -----------------------------------------------------------------------------
module vending_fsm_multi #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned NUM_PRODUCTS = 4,
   parameter int unsigned SEL_W        = 2,
   parameter int unsigned MAX_CREDIT   = 255,
   parameter int unsigned TIMEOUT_CYC  = 1000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          money_inserted,
   input  logic                          inserted_money_valid,
   input  logic [WIDTH-1:0]              inserted_money_value,
   input  logic                          product_selected,
   input  logic [SEL_W-1:0]              product_sel,
   input  logic [NUM_PRODUCTS*WIDTH-1:0] product_cost,
   input  logic [NUM_PRODUCTS-1:0]       product_available,
   input  logic                          cancel,
   output logic                          return_money,
   output logic                          deliver_product,
   output logic [SEL_W-1:0]              delivered_id,
   output logic                          return_change,
   output logic [WIDTH-1:0]              change_value,
   output logic                          sel_error,
   output logic [WIDTH-1:0]              credit,
   output logic                          busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CREDIT,
      S_CHECK,
      S_DELIVER,
      S_CHANGE,
      S_REFUND
   } state_t;

   localparam int unsigned       TMR_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [WIDTH:0]    MAX_SUM  = (WIDTH + 1)'(MAX_CREDIT);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   credit_q, credit_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   delivered_id_q, delivered_id_d;
   logic [WIDTH-1:0]   change_value_q, change_value_d;
   logic               return_money_q, return_money_d;
   logic               deliver_product_q, deliver_product_d;
   logic               return_change_q, return_change_d;
   logic               sel_error_q, sel_error_d;
   logic               busy_q, busy_d;

   // Cost table lookup for the latched index. sel_in_range stays low when the
   // index addresses no slot, which also keeps the part-select in bounds.
   logic [WIDTH-1:0]   sel_cost;
   logic               sel_avail;
   logic               sel_in_range;

   always_comb begin
      sel_cost     = '0;
      sel_avail    = 1'b0;
      sel_in_range = 1'b0;
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_cost     = product_cost[i*WIDTH +: WIDTH];
            sel_avail    = product_available[i];
            sel_in_range = 1'b1;
         end
      end
   end

   // One extra bit so an overflowing sum is detected rather than wrapped.
   logic [WIDTH:0] coin_sum;
   logic           coin_ok;

   always_comb begin
      coin_sum = {1'b0, credit_q} + {1'b0, inserted_money_value};
      coin_ok  = inserted_money_valid && (coin_sum <= MAX_SUM);
   end

   always_comb begin
      state_d           = state_q;
      credit_d          = credit_q;
      timer_d           = '0;
      sel_d             = sel_q;
      delivered_id_d    = delivered_id_q;
      change_value_d    = change_value_q;
      return_money_d    = 1'b0;
      deliver_product_d = 1'b0;
      return_change_d   = 1'b0;
      sel_error_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Cancel still wins arbitration here but has nothing to refund;
            // a coin arriving with it is dropped.
            if (!cancel && money_inserted) begin
               if (coin_ok) begin
                  credit_d = coin_sum[WIDTH-1:0];
                  state_d  = S_CREDIT;
               end else begin
                  return_money_d = 1'b1;
                  change_value_d = inserted_money_value;
               end
            end
         end

         S_CREDIT: begin
            if (cancel) begin
               state_d = S_REFUND;
            end else if (money_inserted) begin
               if (coin_ok) begin
                  credit_d = coin_sum[WIDTH-1:0];
               end else begin
                  return_money_d = 1'b1;
                  change_value_d = inserted_money_value;
               end
            end else if (product_selected) begin
               sel_d   = product_sel;
               state_d = S_CHECK;
            end else if (timer_q == TMR_LAST) begin
               state_d = S_REFUND;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_CHECK: begin
            if (!sel_in_range || !sel_avail || (credit_q < sel_cost)) begin
               sel_error_d = 1'b1;
               state_d     = S_CREDIT;
            end else begin
               credit_d = credit_q - sel_cost;
               state_d  = S_DELIVER;
            end
         end

         S_DELIVER: begin
            deliver_product_d = 1'b1;
            delivered_id_d    = sel_q;
            state_d           = (credit_q != '0) ? S_CHANGE : S_IDLE;
         end

         S_CHANGE: begin
            return_change_d = 1'b1;
            change_value_d  = credit_q;
            credit_d        = '0;
            state_d         = S_IDLE;
         end

         S_REFUND: begin
            return_money_d = 1'b1;
            change_value_d = credit_q;
            credit_d       = '0;
            state_d        = S_IDLE;
         end

         default: begin
            credit_d = '0;
            state_d  = S_IDLE;
         end
      endcase

      busy_d = state_d inside {S_CHECK, S_DELIVER, S_CHANGE, S_REFUND};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= S_IDLE;
         credit_q          <= '0;
         timer_q           <= '0;
         sel_q             <= '0;
         delivered_id_q    <= '0;
         change_value_q    <= '0;
         return_money_q    <= 1'b0;
         deliver_product_q <= 1'b0;
         return_change_q   <= 1'b0;
         sel_error_q       <= 1'b0;
         busy_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         credit_q          <= credit_d;
         timer_q           <= timer_d;
         sel_q             <= sel_d;
         delivered_id_q    <= delivered_id_d;
         change_value_q    <= change_value_d;
         return_money_q    <= return_money_d;
         deliver_product_q <= deliver_product_d;
         return_change_q   <= return_change_d;
         sel_error_q       <= sel_error_d;
         busy_q            <= busy_d;
      end
   end

   assign return_money    = return_money_q;
   assign deliver_product = deliver_product_q;
   assign delivered_id    = delivered_id_q;
   assign return_change   = return_change_q;
   assign change_value    = change_value_q;
   assign sel_error       = sel_error_q;
   assign credit          = credit_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_vending_fsm_multi.sv
// -----------------------------------------------------------------------------
// tb_vending_fsm_multi
//
// Directed bench for vending_fsm_multi. Costs: slot0=40, slot1=75, slot2=65,
// slot3=50. Timeout shortened to 16 cycles. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, so each tick() shows the
// result of the edge that just sampled the inputs.
// -----------------------------------------------------------------------------
module tb_vending_fsm_multi;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NP    = 4;
   localparam int unsigned SW    = 2;
   localparam int unsigned TC    = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              money_inserted;
   logic              inserted_money_valid;
   logic [WIDTH-1:0]  inserted_money_value;
   logic              product_selected;
   logic [SW-1:0]     product_sel;
   logic [NP*WIDTH-1:0] product_cost;
   logic [NP-1:0]     product_available;
   logic              cancel;
   logic              return_money;
   logic              deliver_product;
   logic [SW-1:0]     delivered_id;
   logic              return_change;
   logic [WIDTH-1:0]  change_value;
   logic              sel_error;
   logic [WIDTH-1:0]  credit;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   vending_fsm_multi #(
      .WIDTH        (WIDTH),
      .NUM_PRODUCTS (NP),
      .SEL_W        (SW),
      .MAX_CREDIT   (255),
      .TIMEOUT_CYC  (TC)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .money_inserted       (money_inserted),
      .inserted_money_valid (inserted_money_valid),
      .inserted_money_value (inserted_money_value),
      .product_selected     (product_selected),
      .product_sel          (product_sel),
      .product_cost         (product_cost),
      .product_available    (product_available),
      .cancel               (cancel),
      .return_money         (return_money),
      .deliver_product      (deliver_product),
      .delivered_id         (delivered_id),
      .return_change        (return_change),
      .change_value         (change_value),
      .sel_error            (sel_error),
      .credit               (credit),
      .busy                 (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic valid, input logic [WIDTH-1:0] val);
      money_inserted       = 1'b1;
      inserted_money_valid = valid;
      inserted_money_value = val;
      tick();
      money_inserted       = 1'b0;
      inserted_money_valid = 1'b0;
      inserted_money_value = '0;
   endtask

   task automatic pick(input logic [SW-1:0] idx);
      product_selected = 1'b1;
      product_sel      = idx;
      tick();
      product_selected = 1'b0;
      product_sel      = '0;
   endtask

   task automatic press_cancel();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got 0 expected 1 (simulation time limit)");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      rst_n                = 1'b0;
      money_inserted       = 1'b0;
      inserted_money_valid = 1'b0;
      inserted_money_value = '0;
      product_selected     = 1'b0;
      product_sel          = '0;
      product_cost         = {8'd50, 8'd65, 8'd75, 8'd40};
      product_available    = 4'b1111;
      cancel               = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_credit",  credit, 0);
      check("rst_busy",    busy, 0);
      check("rst_retmon",  return_money, 0);
      check("rst_deliver", deliver_product, 0);
      check("rst_change",  change_value, 0);
      check("rst_id",      delivered_id, 0);
      rst_n = 1'b1;
      tick();

      // Select in IDLE is ignored
      pick(2'd1);
      check("idle_sel_busy", busy, 0);
      tick();
      check("idle_sel_err", sel_error, 0);

      // 1: 50+50, buy slot 1 (75), change 25
      coin(1'b1, 8'd50);
      check("t1_credit50", credit, 50);
      coin(1'b1, 8'd50);
      check("t1_credit100", credit, 100);
      pick(2'd1);
      check("t1_busy_check", busy, 1);
      tick();
      check("t1_sel_err", sel_error, 0);
      check("t1_credit25", credit, 25);
      tick();
      check("t1_deliver", deliver_product, 1);
      check("t1_id", delivered_id, 1);
      check("t1_no_change_yet", return_change, 0);
      tick();
      check("t1_change", return_change, 1);
      check("t1_change_val", change_value, 25);
      check("t1_credit0", credit, 0);
      check("t1_deliver_off", deliver_product, 0);
      check("t1_busy_idle", busy, 0);
      tick();
      check("t1_change_off", return_change, 0);
      check("t1_change_hold", change_value, 25);

      // 2: 50 credit, slot 2 (65) short -> sel_error, then cancel
      coin(1'b1, 8'd50);
      pick(2'd2);
      tick();
      check("t2_sel_err", sel_error, 1);
      check("t2_credit", credit, 50);
      tick();
      check("t2_sel_err_off", sel_error, 0);
      press_cancel();
      check("t2_busy_refund", busy, 1);
      tick();
      check("t2_retmon", return_money, 1);
      check("t2_refund_val", change_value, 50);
      check("t2_credit0", credit, 0);

      // 3: invalid coin in IDLE
      coin(1'b0, 8'd20);
      check("t3_retmon", return_money, 1);
      check("t3_val", change_value, 20);
      check("t3_credit", credit, 0);
      tick();
      check("t3_retmon_off", return_money, 0);

      // 4: overflow reject, exact-ceiling accept, sold-out slot
      coin(1'b1, 8'd100);
      coin(1'b1, 8'd100);
      check("t4_credit200", credit, 200);
      coin(1'b1, 8'd100);
      check("t4_ovf_retmon", return_money, 1);
      check("t4_ovf_val", change_value, 100);
      check("t4_ovf_credit", credit, 200);
      coin(1'b1, 8'd55);
      check("t4_ceiling_retmon", return_money, 0);
      check("t4_ceiling_credit", credit, 255);
      product_available = 4'b1110;
      pick(2'd0);
      tick();
      check("t4_soldout_err", sel_error, 1);
      check("t4_soldout_credit", credit, 255);
      product_available = 4'b1111;
      press_cancel();
      tick();
      check("t4_refund_val", change_value, 255);
      check("t4_refund_retmon", return_money, 1);

      // 5: inactivity timeout; pulse expected TC+1 edges after the coin
      coin(1'b1, 8'd30);
      cnt = 0;
      for (int i = 1; i <= 4 * TC; i++) begin
         tick();
         if (return_money) begin
            cnt = i;
            break;
         end
      end
      check("t5_timeout_cycles", cnt, TC + 1);
      check("t5_timeout_val", change_value, 30);
      check("t5_timeout_credit", credit, 0);

      // 5b: exact-cost purchase, no change pulse
      coin(1'b1, 8'd40);
      pick(2'd0);
      tick();
      check("t5b_credit0", credit, 0);
      tick();
      check("t5b_deliver", deliver_product, 1);
      check("t5b_id", delivered_id, 0);
      tick();
      check("t5b_no_change", return_change, 0);
      check("t5b_busy", busy, 0);

      // 6: cancel beats a coin in the same cycle
      coin(1'b1, 8'd50);
      cancel               = 1'b1;
      money_inserted       = 1'b1;
      inserted_money_valid = 1'b1;
      inserted_money_value = 8'd20;
      tick();
      cancel               = 1'b0;
      money_inserted       = 1'b0;
      inserted_money_valid = 1'b0;
      inserted_money_value = '0;
      check("t6_coin_dropped", credit, 50);
      check("t6_no_reject", return_money, 0);
      tick();
      check("t6_refund", return_money, 1);
      check("t6_refund_val", change_value, 50);

      // 6b: reset while in DELIVER
      coin(1'b1, 8'd75);
      pick(2'd3);
      tick();
      check("t6b_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t6b_busy", busy, 0);
      check("t6b_credit", credit, 0);
      check("t6b_change_val", change_value, 0);
      check("t6b_deliver", deliver_product, 0);
      tick();
      check("t6b_no_deliver", deliver_product, 0);
      check("t6b_no_change", return_change, 0);
      rst_n = 1'b1;
      tick();
      tick();
      check("t6b_quiet_retmon", return_money, 0);
      check("t6b_quiet_deliver", deliver_product, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
